// File: rtl/axi_txn_arbiter.sv
// Grants one AXI address phase at a time, alternating write/read on ties and capping outstanding txns per direction.
// Latency: grant pulse one cycle after a request is sampled in IDLE; all outputs registered.
// Backpressure: a direction at MAX_OUT is ineligible; the address phase holds until aw/ar_done or timeout.
module axi_txn_arbiter #(
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = 4,
    parameter int TMO_CYC = 255,
    parameter int TMO_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_req,
    input  logic             rd_req,
    input  logic             aw_done,
    input  logic             ar_done,
    input  logic             b_done,
    input  logic             r_last_done,
    output logic             wr_gnt,
    output logic             rd_gnt,
    output logic [CNT_W-1:0] wr_out_cnt,
    output logic [CNT_W-1:0] rd_out_cnt,
    output logic             busy,
    output logic             tmo_err,
    output logic             rsp_err
);

    typedef enum logic [1:0] {IDLE, WR_ADDR, RD_ADDR} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic             last_wr;
    logic [TMO_W-1:0] tmo_cnt;
    logic             ew, er, in_wr, in_rd;
    logic             wr_inc, rd_inc, wr_dec, rd_dec;
    logic             uflow, stray, tmo_hit;
    logic             gnt_w, gnt_r;
    logic [CNT_W-1:0] wr_cnt_nxt, rd_cnt_nxt;

    always_comb begin
        in_wr  = (state == WR_ADDR);
        in_rd  = (state == RD_ADDR);
        ew     = wr_req && (wr_out_cnt < MAX_CNT);
        er     = rd_req && (rd_out_cnt < MAX_CNT);
        wr_inc = aw_done && in_wr;
        rd_inc = ar_done && in_rd;
        wr_dec = b_done && (wr_out_cnt != '0);
        rd_dec = r_last_done && (rd_out_cnt != '0);
        uflow  = (b_done && (wr_out_cnt == '0)) || (r_last_done && (rd_out_cnt == '0));
        stray  = (aw_done && !in_wr) || (ar_done && !in_rd);
        // A done arriving in the expiry cycle takes priority over the timeout.
        tmo_hit = (TMO_CYC != 0) && (tmo_cnt == TMO_LAST) &&
                  ((in_wr && !aw_done) || (in_rd && !ar_done));

        wr_cnt_nxt = wr_out_cnt;
        if (wr_inc && !wr_dec)
            wr_cnt_nxt = wr_out_cnt + CNT_W'(1);
        else if (!wr_inc && wr_dec)
            wr_cnt_nxt = wr_out_cnt - CNT_W'(1);

        rd_cnt_nxt = rd_out_cnt;
        if (rd_inc && !rd_dec)
            rd_cnt_nxt = rd_out_cnt + CNT_W'(1);
        else if (!rd_inc && rd_dec)
            rd_cnt_nxt = rd_out_cnt - CNT_W'(1);

        state_nxt = state;
        gnt_w     = 1'b0;
        gnt_r     = 1'b0;
        case (state)
            IDLE: begin
                // On a tie, the direction not granted last time wins.
                if (ew && (!er || !last_wr)) begin
                    state_nxt = WR_ADDR;
                    gnt_w     = 1'b1;
                end else if (er) begin
                    state_nxt = RD_ADDR;
                    gnt_r     = 1'b1;
                end
            end
            WR_ADDR: if (aw_done || tmo_hit) state_nxt = IDLE;
            RD_ADDR: if (ar_done || tmo_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_wr    <= 1'b0;
            tmo_cnt    <= '0;
            wr_out_cnt <= '0;
            rd_out_cnt <= '0;
            wr_gnt     <= 1'b0;
            rd_gnt     <= 1'b0;
            busy       <= 1'b0;
            tmo_err    <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_gnt     <= gnt_w;
            rd_gnt     <= gnt_r;
            if (gnt_w)
                last_wr <= 1'b1;
            else if (gnt_r)
                last_wr <= 1'b0;
            tmo_cnt    <= (state == IDLE) ? '0 : tmo_cnt + TMO_W'(1);
            wr_out_cnt <= wr_cnt_nxt;
            rd_out_cnt <= rd_cnt_nxt;
            busy       <= (state_nxt != IDLE) || (wr_cnt_nxt != '0) || (rd_cnt_nxt != '0);
            tmo_err    <= tmo_hit;
            rsp_err    <= uflow || stray;
        end
    end

endmodule
